// File: rtl/rv_isa_pkg.sv
// Shared RV32I opcode values, ALU_operation codes and instruction formats.
package rv_isa_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_ALT     = 7'b0100000;

    typedef enum logic [4:0] {
        OP_LW    = 5'd0,
        OP_ADDI  = 5'd1,  OP_SLLI = 5'd2,  OP_SLTI = 5'd3,  OP_SLTIU = 5'd4,
        OP_XORI  = 5'd5,  OP_SRLI = 5'd6,  OP_SRAI = 5'd7,  OP_ORI   = 5'd8,
        OP_ANDI  = 5'd9,
        OP_AUIPC = 5'd10,
        OP_SB    = 5'd11, OP_SH   = 5'd12, OP_SW   = 5'd13,
        OP_ADD   = 5'd14, OP_SUB  = 5'd15, OP_SLL  = 5'd16, OP_SLT   = 5'd17,
        OP_SLTU  = 5'd18, OP_XOR  = 5'd19, OP_SRL  = 5'd20, OP_SRA   = 5'd21,
        OP_OR    = 5'd22, OP_AND  = 5'd23,
        OP_LUI   = 5'd24,
        OP_BEQ   = 5'd25, OP_BNE  = 5'd26, OP_BLT  = 5'd27, OP_BGE   = 5'd28,
        OP_BLTU  = 5'd29, OP_BGEU = 5'd30,
        OP_JAL   = 5'd31
    } alu_op_e;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational encoder: ALU_operation code plus fields -> RV32I word and immediate-range flag.
module instr_pack
    import rv_isa_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] instr,
    output logic        imm_ok
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    fmt_e       fmt;

    always_comb begin
        opc = OPC_OP;
        f3  = 3'b000;
        f7  = 7'b0000000;
        fmt = FMT_R;
        case (alu_op_e'(op))
            OP_LW:    begin opc = OPC_LOAD;   f3 = 3'b010; fmt = FMT_I;  end
            OP_ADDI:  begin opc = OPC_OP_IMM; f3 = 3'b000; fmt = FMT_I;  end
            OP_SLLI:  begin opc = OPC_OP_IMM; f3 = 3'b001; fmt = FMT_SH; end
            OP_SLTI:  begin opc = OPC_OP_IMM; f3 = 3'b010; fmt = FMT_I;  end
            OP_SLTIU: begin opc = OPC_OP_IMM; f3 = 3'b011; fmt = FMT_I;  end
            OP_XORI:  begin opc = OPC_OP_IMM; f3 = 3'b100; fmt = FMT_I;  end
            OP_SRLI:  begin opc = OPC_OP_IMM; f3 = 3'b101; fmt = FMT_SH; end
            OP_SRAI:  begin opc = OPC_OP_IMM; f3 = 3'b101; f7 = F7_ALT; fmt = FMT_SH; end
            OP_ORI:   begin opc = OPC_OP_IMM; f3 = 3'b110; fmt = FMT_I;  end
            OP_ANDI:  begin opc = OPC_OP_IMM; f3 = 3'b111; fmt = FMT_I;  end
            OP_AUIPC: begin opc = OPC_AUIPC;  fmt = FMT_U; end
            OP_SB:    begin opc = OPC_STORE;  f3 = 3'b000; fmt = FMT_S;  end
            OP_SH:    begin opc = OPC_STORE;  f3 = 3'b001; fmt = FMT_S;  end
            OP_SW:    begin opc = OPC_STORE;  f3 = 3'b010; fmt = FMT_S;  end
            OP_ADD:   f3 = 3'b000;
            OP_SUB:   begin f3 = 3'b000; f7 = F7_ALT; end
            OP_SLL:   f3 = 3'b001;
            OP_SLT:   f3 = 3'b010;
            OP_SLTU:  f3 = 3'b011;
            OP_XOR:   f3 = 3'b100;
            OP_SRL:   f3 = 3'b101;
            OP_SRA:   begin f3 = 3'b101; f7 = F7_ALT; end
            OP_OR:    f3 = 3'b110;
            OP_AND:   f3 = 3'b111;
            OP_LUI:   begin opc = OPC_LUI;    fmt = FMT_U; end
            OP_BEQ:   begin opc = OPC_BRANCH; f3 = 3'b000; fmt = FMT_B; end
            OP_BNE:   begin opc = OPC_BRANCH; f3 = 3'b001; fmt = FMT_B; end
            OP_BLT:   begin opc = OPC_BRANCH; f3 = 3'b100; fmt = FMT_B; end
            OP_BGE:   begin opc = OPC_BRANCH; f3 = 3'b101; fmt = FMT_B; end
            OP_BLTU:  begin opc = OPC_BRANCH; f3 = 3'b110; fmt = FMT_B; end
            OP_BGEU:  begin opc = OPC_BRANCH; f3 = 3'b111; fmt = FMT_B; end
            OP_JAL:   begin opc = OPC_JAL;    fmt = FMT_J; end
            default:  fmt = FMT_R;
        endcase
    end

    // Signed range checks reduce to "all bits above the field equal the field's sign bit".
    always_comb begin
        instr  = 32'h0;
        imm_ok = 1'b0;
        case (fmt)
            FMT_R: begin
                instr  = {f7, rs2, rs1, f3, rd, opc};
                imm_ok = 1'b1;
            end
            FMT_I: begin
                instr  = {imm[11:0], rs1, f3, rd, opc};
                imm_ok = (&imm[31:11]) || (~|imm[31:11]);
            end
            FMT_SH: begin
                instr  = {f7, imm[4:0], rs1, f3, rd, opc};
                imm_ok = ~|imm[31:5];
            end
            FMT_S: begin
                instr  = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
                imm_ok = (&imm[31:11]) || (~|imm[31:11]);
            end
            FMT_B: begin
                instr  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
                imm_ok = ((&imm[31:12]) || (~|imm[31:12])) && !imm[0];
            end
            FMT_U: begin
                instr  = {imm[19:0], rd, opc};
                imm_ok = ~|imm[31:20];
            end
            FMT_J: begin
                instr  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
                imm_ok = ((&imm[31:20]) || (~|imm[31:20])) && !imm[0];
            end
            default: begin
                instr  = 32'h0;
                imm_ok = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Encodes ALU_operation requests into RV32I words for instruction memory; 1-cycle latency,
// single output register, input stalled (in_ready=0) while a word waits on out_ready or load_en is high.
module instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  emit_cnt
);

    logic [31:0]       pack_instr;
    logic              pack_ok;
    logic [ADDR_W-1:0] addr_cnt;
    logic              accept;
    logic              handoff;

    instr_pack u_pack (
        .op     (in_op),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .imm    (in_imm),
        .instr  (pack_instr),
        .imm_ok (pack_ok)
    );

    assign in_ready = !load_en && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_instr  <= 32'h0;
            out_addr   <= '0;
            addr_cnt   <= '0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            emit_cnt   <= '0;
        end else begin
            err_pulse <= accept && !pack_ok;
            if (accept && !pack_ok) begin
                err_sticky <= 1'b1;
            end
            if (handoff && (emit_cnt != '1)) begin
                emit_cnt <= emit_cnt + 1'b1;
            end
            // load_en and accept are mutually exclusive, so the counter has one writer per cycle.
            if (load_en) begin
                addr_cnt <= load_addr;
            end
            if (accept && pack_ok) begin
                out_valid <= 1'b1;
                out_instr <= pack_instr;
                out_addr  <= addr_cnt;
                addr_cnt  <= addr_cnt + 1'b1;
            end else if (handoff) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed checks of instr_encoder against a behavioural model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = 8'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_op = 5'd0;
    logic [4:0]  in_rd = 5'd0;
    logic [4:0]  in_rs1 = 5'd0;
    logic [4:0]  in_rs2 = 5'd0;
    logic [31:0] in_imm = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_instr;
    logic [7:0]  out_addr;
    logic        err_pulse;
    logic        err_sticky;
    logic [15:0] emit_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    instr_encoder #(.ADDR_W(8), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .emit_cnt   (emit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder built from field positions with integer arithmetic.
    function automatic logic [31:0] m_encode(input int op, input int rd, input int rs1,
                                             input int rs2, input logic [31:0] imm);
        int iv;
        int w;
        int f3;
        int low;
        int f3_imm [9] = '{0, 1, 2, 3, 4, 5, 5, 6, 7};
        int f3_reg [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
        int f3_br  [6] = '{0, 1, 4, 5, 6, 7};
        iv = int'(imm);
        w  = 0;
        if (op == 0) begin
            w = 3 | (2 << 12) | (rd << 7) | (rs1 << 15) | ((iv & 4095) << 20);
        end else if (op <= 9) begin
            f3 = f3_imm[op - 1];
            if (op == 2 || op == 6 || op == 7)
                low = (iv & 31) | ((op == 7) ? 1024 : 0);
            else
                low = iv & 4095;
            w = 19 | (rd << 7) | (f3 << 12) | (rs1 << 15) | (low << 20);
        end else if (op == 10 || op == 24) begin
            w = ((op == 10) ? 'h17 : 'h37) | (rd << 7) | ((iv & 'hFFFFF) << 12);
        end else if (op <= 13) begin
            w = 'h23 | ((iv & 31) << 7) | ((op - 11) << 12) | (rs1 << 15) | (rs2 << 20)
                | (((iv >>> 5) & 127) << 25);
        end else if (op <= 23) begin
            f3 = f3_reg[op - 14];
            w = 'h33 | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
                | ((op == 15 || op == 21) ? (1 << 30) : 0);
        end else if (op <= 30) begin
            f3 = f3_br[op - 25];
            w = 'h63 | (((iv >>> 11) & 1) << 7) | (((iv >>> 1) & 15) << 8) | (f3 << 12)
                | (rs1 << 15) | (rs2 << 20) | (((iv >>> 5) & 63) << 25) | (((iv >>> 12) & 1) << 31);
        end else begin
            w = 'h6F | (rd << 7) | (((iv >>> 12) & 255) << 12) | (((iv >>> 11) & 1) << 20)
                | (((iv >>> 1) & 1023) << 21) | (((iv >>> 20) & 1) << 31);
        end
        return w;
    endfunction

    function automatic logic m_legal(input int op, input logic [31:0] imm);
        int iv;
        iv = int'(imm);
        if (op == 2 || op == 6 || op == 7) return iv >= 0 && iv <= 31;
        if (op >= 14 && op <= 23)         return 1'b1;
        if (op == 10 || op == 24)         return (imm >> 20) == 0;
        if (op >= 25 && op <= 30)         return iv >= -4096 && iv <= 4094 && (iv & 1) == 0;
        if (op == 31)                     return iv >= -1048576 && iv <= 1048574 && (iv & 1) == 0;
        return iv >= -2048 && iv <= 2047;
    endfunction

    // Model state: what the DUT registers must hold after each rising edge.
    bit          armed = 0;
    logic        m_valid;
    logic [31:0] m_instr;
    int          m_addr;
    int          m_ctr;
    logic        m_err;
    logic        m_sticky;
    int          m_emit;

    always @(negedge clk) begin
        logic exp_rdy;
        logic acc;
        logic ok;
        logic hand;
        exp_rdy = !load_en && (!m_valid || out_ready);
        if (armed) begin
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("out_instr", out_instr, m_instr);
                chk("out_addr", 32'(out_addr), m_addr);
            end
            chk("err_pulse", 32'(err_pulse), 32'(m_err));
            chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
            chk("emit_cnt", 32'(emit_cnt), m_emit);
        end
        if (rst) begin
            armed = 1;
            m_valid = 0; m_instr = 0; m_addr = 0; m_ctr = 0;
            m_err = 0; m_sticky = 0; m_emit = 0;
        end else if (armed) begin
            acc  = in_valid && exp_rdy;
            ok   = m_legal(int'(in_op), in_imm);
            hand = m_valid && out_ready;
            m_err = acc && !ok;
            if (m_err) m_sticky = 1;
            if (hand && m_emit < 65535) m_emit++;
            if (acc && ok) begin
                m_valid = 1;
                m_instr = m_encode(int'(in_op), int'(in_rd), int'(in_rs1), int'(in_rs2), in_imm);
                m_addr  = m_ctr;
                m_ctr   = (m_ctr + 1) % 256;
            end else if (hand) begin
                m_valid = 0;
            end
            if (load_en) m_ctr = int'(load_addr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; in_valid = 0; load_en = 0; out_ready = 1;
        step(); step();
        rst = 0;
    endtask

    task automatic req(input int op, input int rd, input int rs1, input int rs2,
                       input logic [31:0] imm);
        in_valid = 1;
        in_op  = 5'(op);
        in_rd  = 5'(rd);
        in_rs1 = 5'(rs1);
        in_rs2 = 5'(rs2);
        in_imm = imm;
    endtask

    initial begin
        int s;
        // Pin the reference functions to hand-encoded words.
        chk("model_add", m_encode(14, 3, 1, 2, 0), 32'h002081B3);
        chk("model_addi", m_encode(1, 1, 0, 0, 32'hFFFFFFFF), 32'hFFF00093);
        chk("model_beq", m_encode(25, 0, 1, 2, 32'hFFFFFFFC), 32'hFE208EE3);
        chk("model_jal", m_encode(31, 1, 0, 0, 2048), 32'h001000EF);
        chk("model_legal_i", 32'(m_legal(1, 2048)), 0);
        chk("model_legal_b", 32'(m_legal(25, 3)), 0);
        chk("model_legal_j", 32'(m_legal(31, 32'hFFF00000)), 1);

        do_reset();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_instr", out_instr, 0);
        chk("rst_addr", 32'(out_addr), 0);
        chk("rst_emit", 32'(emit_cnt), 0);
        chk("rst_sticky", 32'(err_sticky), 0);
        chk("rst_err", 32'(err_pulse), 0);

        req(14, 3, 1, 2, 0); step();
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_instr", out_instr, 32'h002081B3);
        chk("t1_addr", 32'(out_addr), 0);

        do_reset();
        req(1, 1, 0, 0, 32'hFFFFFFFF); step();
        chk("t2_w0", out_instr, 32'hFFF00093); chk("t2_a0", 32'(out_addr), 0);
        req(13, 0, 1, 2, 8); step();
        chk("t2_w1", out_instr, 32'h0020A423); chk("t2_a1", 32'(out_addr), 1);
        req(7, 5, 5, 0, 3); step();
        chk("t2_w2", out_instr, 32'h4032D293); chk("t2_a2", 32'(out_addr), 2);
        in_valid = 0; step();
        chk("t2_emit", 32'(emit_cnt), 3);
        chk("t2_drop", 32'(out_valid), 0);

        req(25, 0, 1, 2, 32'hFFFFFFFC); step();
        chk("t3_beq", out_instr, 32'hFE208EE3);
        req(31, 1, 0, 0, 2048); step();
        chk("t3_jal", out_instr, 32'h001000EF);
        chk("t3_addr", 32'(out_addr), 4);

        out_ready = 0; req(14, 3, 1, 2, 0); #1;
        chk("t4_rdy_lo", 32'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold_instr", out_instr, 32'h001000EF);
            chk("t4_hold_addr", 32'(out_addr), 4);
            chk("t4_hold_rdy", 32'(in_ready), 0);
        end
        out_ready = 1; #1;
        chk("t4_rdy_hi", 32'(in_ready), 1);
        step();
        chk("t4_instr", out_instr, 32'h002081B3);
        chk("t4_addr", 32'(out_addr), 5);

        req(1, 1, 0, 0, 2048); step();
        chk("t5_novalid0", 32'(out_valid), 0);
        chk("t5_err0", 32'(err_pulse), 1);
        req(25, 0, 1, 2, 3); step();
        chk("t5_novalid1", 32'(out_valid), 0);
        chk("t5_err1", 32'(err_pulse), 1);
        in_valid = 0; step();
        chk("t5_err_clr", 32'(err_pulse), 0);
        chk("t5_sticky", 32'(err_sticky), 1);
        req(14, 3, 1, 2, 0); step();
        chk("t5_addr", 32'(out_addr), 6);

        load_en = 1; load_addr = 8'hFF; #1;
        chk("t6_rdy_load", 32'(in_ready), 0);
        step();
        load_en = 0; step();
        chk("t6_addr_ff", 32'(out_addr), 8'hFF);
        step();
        chk("t6_addr_wrap", 32'(out_addr), 0);
        in_valid = 0; step();

        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            load_en   = ($urandom_range(0, 15) == 0);
            load_addr = 8'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_op     = 5'($urandom);
            in_rd     = 5'($urandom);
            in_rs1    = 5'($urandom);
            in_rs2    = 5'($urandom);
            case ($urandom_range(0, 4))
                0: s = int'($urandom_range(0, 80)) - 40;
                1: s = int'($urandom_range(0, 10000)) - 5000;
                2: s = int'($urandom);
                3: s = int'($urandom_range(0, 'hFFFFF));
                default: s = int'($urandom_range(0, 2097152)) - 1048576;
            endcase
            in_imm = s;
            step();
        end
        rst = 0; load_en = 0; in_valid = 0; out_ready = 1;
        step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the decode controller: takes an ALU_operation code (0-31) plus register and immediate fields, and emits a 32-bit RV32I instruction word.
- Emitted words go to the instruction-memory write port through a valid/ready stage, with an auto-incrementing write address.
- Used by the loader and self-test paths to build programs from the same op-code space the controller decodes.

Parameters:
ADDR_W, 8, instruction-memory word address width; address wraps modulo 2^ADDR_W
CNT_W, 16, width of emitted-instruction counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
load_en  in  1  load write-address counter
load_addr  in  ADDR_W  value loaded when load_en
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid&&in_ready
in_op  in  5  ALU_operation code, same encoding as the controller
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_imm  in  32  signed immediate; byte offset for B/J; upper-20 value for U
out_valid  out  1  out_instr/out_addr valid
out_ready  in  1  memory accepts the word
out_instr  out  32  encoded instruction
out_addr  out  ADDR_W  write address for out_instr
err_pulse  out  1  one-cycle flag: accepted request rejected for immediate range
err_sticky  out  1  set by err_pulse, cleared only by rst
emit_cnt  out  CNT_W  count of words handed off (out_valid&&out_ready); saturates

Behaviour:
- Reset: out_valid=0, out_instr=0, out_addr=0, address counter=0, err_pulse=0, err_sticky=0, emit_cnt=0.
- Op map (opcode/funct3/funct7):
  - 0: LW, 0000011, f3=010.
  - 1-9: OP-IMM 0010011, in order ADDI 000, SLLI 001, SLTI 010, SLTIU 011, XORI 100, SRLI 101 with f7=0, SRAI 101 with f7=0100000, ORI 110, ANDI 111.
  - 10: AUIPC 0010111.
  - 11-13: SB/SH/SW, 0100011, f3 000/001/010.
  - 14-23: OP 0110011, in order ADD, SUB (f7=0100000), SLL, SLT, SLTU, XOR, SRL, SRA (f7=0100000), OR, AND, with f3 000,000,001,010,011,100,101,101,110,111.
  - 24: LUI 0110111.
  - 25-30: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111, opcode 1100011.
  - 31: JAL 1101111.
- Unused fields per format are not inserted into the word: R uses rd/rs1/rs2; I uses rd/rs1; S/B use rs1/rs2; U/J use rd.
- Immediate legality:
  - I/S: -2048..2047.
  - Shifts (2, 6, 7): 0..31.
  - B: -4096..4094, and bit0 must be 0.
  - J: -1048576..1048574, and bit0 must be 0.
  - U: in_imm[31:20] must be 0.
  - Opcodes 14-23 ignore in_imm.
- in_ready = !load_en && (!out_valid || out_ready). Single output register, so full throughput with out_ready held high.
- On accept with a legal immediate: next cycle out_valid=1, out_instr=encoding, out_addr=counter; the counter increments and wraps from 2^ADDR_W-1 to 0. Latency is 1 cycle.
- On accept with an illegal immediate: no word is emitted, the counter does not change, and err_pulse=1 next cycle. err_sticky is set. An already-pending output is unaffected.
- out_valid&&!out_ready: out_instr and out_addr are held stable, and in_ready=0.
- Handoff with a simultaneous accept updates the output register in the same cycle, with no bubble. With no new accept, out_valid drops.
- load_en has priority: counter=load_addr next cycle, and no request is accepted that cycle. A pending output keeps its old out_addr.
- rst mid-stream drops any pending output and does not complete the handoff.
- emit_cnt increments on each out_valid&&out_ready and saturates at all-ones.

Decomposition:
- Shared package rv_isa_pkg holds:
  - the opcode localparams (same values as the controller's);
  - the ALU_operation code constants 0-31 as an enum alu_op_e;
  - format enum fmt_e {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J}.
- One combinational sub-module, instr_pack: op/fields to {instr, imm_ok}. The top module holds the handshake, counter, error and statistics logic.

Test Plan:
1. rst; op=14, rd=3, rs1=1, rs2=2 -> next cycle out_valid=1, out_instr=0x002081B3, out_addr=0.
2. Back-to-back with out_ready=1: op=1 (rd=1, rs1=0, imm=-1); op=13 (rs1=1, rs2=2, imm=8); op=7 (rd=5, rs1=5, imm=3) -> 0xFFF00093@0, 0x0020A423@1, 0x4032D293@2, one per cycle; emit_cnt=3.
3. op=25 (rs1=1, rs2=2, imm=-4), then op=31 (rd=1, imm=2048) -> 0xFE208EE3, then 0x001000EF.
4. Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_instr/out_addr stable, counter unchanged; release -> next request accepted in the same cycle.
5. op=1, imm=2048; and op=25, imm=3 -> no out_valid; err_pulse for 1 cycle each; err_sticky=1; next legal word uses the unchanged address.
6. load_en with load_addr=0xFF, then two legal requests -> out_addr 0xFF then 0x00 (wrap); load_en asserted together with in_valid -> in_ready=0 that cycle.
